// File: rtl/cell_pack_buffer_pkg.sv
// Constants shared by the cell packer, fetch and HOG stages, plus the occupancy encoding
// for the two-slot packed-cell store.
package cell_pack_buffer_pkg;

    localparam int PIX_W  = 8;
    localparam int CELL_S = 10;
    localparam int PIX_N  = CELL_S*CELL_S - 4;
    localparam int IN_W   = PIX_W*PIX_N;
    localparam int K_W    = $clog2(PIX_N);
    localparam int RC_W   = $clog2(CELL_S);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/cell_ping_pong.sv
// Two-slot packed-cell store with byte write enable; head slot visible combinationally.
// A completed cell is readable the cycle after its last byte edge; a pop frees a slot on the same edge.
module cell_ping_pong
    import cell_pack_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [K_W-1:0]   wr_idx_i,
    input  logic [PIX_W-1:0] wr_pix_i,
    input  logic             complete_i,
    input  logic             pop_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [IN_W-1:0]  rd_dat_o
);

    occ_e            occ_q, occ_d;
    logic            wptr_q, rptr_q;
    logic [IN_W-1:0] slot_q [2];
    logic            pop;

    assign pop = pop_i & (occ_q != OCC_EMPTY);

    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY: if (complete_i) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (complete_i && !pop)      occ_d = OCC_FULL;
                else if (!complete_i && pop) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop && !complete_i) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    // The write slot is always the free one: acceptance upstream is gated by full_o.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q     <= OCC_EMPTY;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            occ_q <= occ_d;
            if (complete_i) wptr_q <= ~wptr_q;
            if (pop)        rptr_q <= ~rptr_q;
            if (wr_en_i)    slot_q[wptr_q][wr_idx_i*PIX_W +: PIX_W] <= wr_pix_i;
        end
    end

    assign ready_o  = (occ_q != OCC_EMPTY);
    assign full_o   = (occ_q == OCC_FULL);
    assign rd_dat_o = slot_q[rptr_q];

endmodule

// File: rtl/cell_pack_buffer.sv
// Packs a byte pixel stream of bordered cells into corner-free words, served by ready/request pull.
// Cell ready the cycle after its last pixel; i_rdy = ~full | request. CELL_CORNER_DROP_EN: stream carries corners.
module cell_pack_buffer
    import cell_pack_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [PIX_W-1:0] i_pix,
    output logic             i_rdy,
    output logic             ready,
    input  logic             request,
    output logic [IN_W-1:0]  o_data,
    output logic             o_drop
);

    logic           full;
    logic           acc;
    logic           wr_en;
    logic [K_W-1:0] wr_idx;
    logic           complete;
    logic           drop_q, drop_d;

    assign i_rdy = ~full | request;
    assign acc   = i_valid & i_rdy;

`ifdef CELL_CORNER_DROP_EN
    logic [RC_W-1:0] row_q, row_d, col_q, col_d;
    logic [K_W-1:0]  k_q, k_d;
    logic            idle, corner, last;

    // Raster (0,0) only ever holds the SOF pixel, so it doubles as the resync state.
    assign idle   = (row_q == '0) && (col_q == '0);
    assign corner = ((row_q == '0) || (row_q == RC_W'(CELL_S-1))) &&
                    ((col_q == '0) || (col_q == RC_W'(CELL_S-1)));
    assign last   = (row_q == RC_W'(CELL_S-1)) && (col_q == RC_W'(CELL_S-1));

    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        wr_en    = 1'b0;
        wr_idx   = k_q;
        complete = 1'b0;
        drop_d   = 1'b0;
        if (acc) begin
            if (i_sof) begin
                drop_d = ~idle;
                row_d  = '0;
                col_d  = RC_W'(1);
                k_d    = '0;
            end else if (!idle) begin
                wr_en = ~corner;
                if (!corner) k_d = k_q + K_W'(1);
                if (last) begin
                    complete = 1'b1;
                    row_d    = '0;
                    col_d    = '0;
                    k_d      = '0;
                end else if (col_q == RC_W'(CELL_S-1)) begin
                    col_d = '0;
                    row_d = row_q + RC_W'(1);
                end else begin
                    col_d = col_q + RC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
            k_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            k_q   <= k_d;
        end
    end
`else
    logic [K_W-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d   = pcnt_q;
        wr_en    = 1'b0;
        wr_idx   = pcnt_q;
        complete = 1'b0;
        drop_d   = 1'b0;
        if (acc) begin
            if (i_sof) begin
                drop_d = (pcnt_q != '0);
                wr_en  = 1'b1;
                wr_idx = '0;
                pcnt_d = K_W'(1);
            end else if (pcnt_q != '0) begin
                wr_en = 1'b1;
                if (pcnt_q == K_W'(PIX_N-1)) begin
                    complete = 1'b1;
                    pcnt_d   = '0;
                end else begin
                    pcnt_d = pcnt_q + K_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pcnt_q <= '0;
        else      pcnt_q <= pcnt_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) drop_q <= 1'b0;
        else      drop_q <= drop_d;
    end

    assign o_drop = drop_q;

    cell_ping_pong u_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_pix_i   (i_pix),
        .complete_i (complete),
        .pop_i      (request),
        .ready_o    (ready),
        .full_o     (full),
        .rd_dat_o   (o_data)
    );

endmodule

// File: tb/tb_cell_pack_buffer.sv
// Directed bench for cell_pack_buffer: vector table for SOF/drop/resync, hand sequences for fill/pop.
module tb_cell_pack_buffer;
    import cell_pack_buffer_pkg::*;

`ifdef CELL_CORNER_DROP_EN
    localparam int CELLN = CELL_S*CELL_S;
`else
    localparam int CELLN = PIX_N;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid, i_sof, request;
    logic [PIX_W-1:0] i_pix;
    logic             i_rdy, ready, o_drop;
    logic [IN_W-1:0]  o_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cell_pack_buffer dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_pix   (i_pix),
        .i_rdy   (i_rdy),
        .ready   (ready),
        .request (request),
        .o_data  (o_data),
        .o_drop  (o_drop)
    );

    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] pix;
        logic       req;
        logic       e_drop;
        logic       e_ready;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sof, input logic [PIX_W-1:0] pix);
        int n = 0;
        i_valid = 1'b1;
        i_sof   = sof;
        i_pix   = pix;
        while (!i_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!i_rdy) begin
            checks++;
            failures++;
            $display("FAIL push_timeout i_rdy=0 exp=1");
        end
        tick();
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    // Pushes raster pixels [from, to) of a cell whose raster value is base + index.
    task automatic push_range(input logic [7:0] base, input int from, input int to);
        for (int r = from; r < to; r++) push(r == 0, base + 8'(r));
    endtask

    task automatic pop1();
        request = 1'b1;
        tick();
        request = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [IN_W-1:0] exp_word(input logic [7:0] base);
        logic [IN_W-1:0] w;
        int k;
        w = '0;
        k = 0;
        for (int r = 0; r < CELLN; r++) begin
`ifdef CELL_CORNER_DROP_EN
            int row, col;
            row = r / CELL_S;
            col = r % CELL_S;
            if ((row == 0 || row == CELL_S-1) && (col == 0 || col == CELL_S-1)) continue;
`endif
            w[k*PIX_W +: PIX_W] = base + 8'(r);
            k++;
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time_exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_pix = '0; request = 1'b0;
        tv[0] = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0};
        tv[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_i_rdy", i_rdy, 1);
        chk("rst_drop", o_drop, 0);
        chk("rst_data", o_data, '0);
        rst = 1'b1;
        tick();

        // SOF / drop / resync vectors
        for (int i = 0; i < 8; i++) begin
            i_valid = tv[i].v; i_sof = tv[i].sof; i_pix = tv[i].pix; request = tv[i].req;
            tick();
            chk($sformatf("tv%0d_drop", i), o_drop, tv[i].e_drop);
            chk($sformatf("tv%0d_ready", i), ready, tv[i].e_ready);
        end
        i_valid = 1'b0; i_sof = 1'b0; request = 1'b0;
        push_range(8'h30, 1, CELLN);
        chk("tv_tail_ready", ready, 1);
        chk("tv_tail_word", o_data, exp_word(8'h30));
        pop1();
        do_reset();

        // Single cell, latency and boundary bytes
        push_range(8'h00, 0, CELLN-1);
        chk("c1_ready_before_last", ready, 0);
        push(1'b0, 8'(CELLN-1));
        chk("c1_ready", ready, 1);
        chk("c1_word", o_data, exp_word(8'h00));
`ifdef CELL_CORNER_DROP_EN
        chk("c1_byte0", o_data[7:0], 8'd1);
        chk("c1_byte1", o_data[15:8], 8'd2);
        chk("c1_last", o_data[IN_W-1 -: 8], 8'd98);
`else
        chk("c1_byte0", o_data[7:0], 8'h00);
        chk("c1_last", o_data[IN_W-1 -: 8], 8'h5F);
`endif
        pop1();
        chk("c1_ready_after_pop", ready, 0);

        // Three cells, third stalls until a pop; then back-to-back pops
        push_range(8'h10, 0, CELLN);
        push_range(8'h40, 0, CELLN);
        chk("s3_i_rdy_full", i_rdy, 0);
        chk("s3_head_a", o_data, exp_word(8'h10));
        i_valid = 1'b1; i_sof = 1'b1; i_pix = 8'h80;
        repeat (3) tick();
        chk("s3_stall_i_rdy", i_rdy, 0);
        request = 1'b1;
        #1;
        chk("s3_i_rdy_on_req", i_rdy, 1);
        tick();
        request = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
        chk("s3_head_b", o_data, exp_word(8'h40));
        push_range(8'h80, 1, CELLN);
        chk("s3_full_again", i_rdy, 0);
        request = 1'b1;
        tick();
        chk("s3_head_c", o_data, exp_word(8'h80));
        chk("s3_ready_c", ready, 1);
        tick();
        request = 1'b0;
        chk("s3_empty", ready, 0);

        // Completion coinciding with a pop
        push_range(8'h05, 0, CELLN);
        push_range(8'h35, 0, CELLN);
        chk("cp_head_a", o_data, exp_word(8'h05));
        request = 1'b1; i_valid = 1'b1; i_sof = 1'b1; i_pix = 8'hC0;
        tick();
        request = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
        chk("cp_head_b", o_data, exp_word(8'h35));
        push_range(8'hC0, 1, CELLN-1);
        request = 1'b1;
        push(1'b0, 8'hC0 + 8'(CELLN-1));
        request = 1'b0;
        chk("cp_ready_held", ready, 1);
        chk("cp_head_c", o_data, exp_word(8'hC0));
        pop1();
        chk("cp_empty", ready, 0);

        // SOF arriving at pixel 40 of a cell
        push_range(8'h50, 0, 40);
        chk("sd_no_drop_yet", o_drop, 0);
        push(1'b1, 8'h90);
        chk("sd_drop_pulse", o_drop, 1);
        tick();
        chk("sd_drop_once", o_drop, 0);
        push_range(8'h90, 1, CELLN);
        chk("sd_word", o_data, exp_word(8'h90));
        pop1();

        // Reset with a stored cell and a half-filled one
        push_range(8'h21, 0, CELLN);
        push_range(8'h60, 0, CELLN/2);
        chk("mr_ready_pre", ready, 1);
        rst = 1'b0;
        tick();
        chk("mr_ready", ready, 0);
        chk("mr_data", o_data, '0);
        chk("mr_drop", o_drop, 0);
        chk("mr_i_rdy", i_rdy, 1);
        rst = 1'b1;
        for (int r = 0; r < CELLN; r++) push(1'b0, 8'h33);
        chk("mr_unsynced_ignored", ready, 0);
        chk("mr_unsynced_no_drop", o_drop, 0);
        push_range(8'h77, 0, CELLN);
        chk("mr_fresh_ready", ready, 1);
        chk("mr_fresh_word", o_data, exp_word(8'h77));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
